// File: rtl/instruction_fetch.sv
// Instruction fetch front end for the accumulator CPU: owns the PC, reads the
// synchronous program memory, splits the instruction word and parks on HLT.
module instruction_fetch #(
  parameter int ADDR_W  = 11,
  parameter int OPC_W   = 5,
  parameter int DATA_W  = 16,
  parameter int COUNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      WrPC,
  input  logic [DATA_W-1:0]         instr_data,
  output logic [ADDR_W-1:0]         pm_addr,
  output logic                      pm_rd,
  output logic [OPC_W-1:0]          OpCode,
  output logic [DATA_W-OPC_W-1:0]   Operand,
  output logic                      instr_valid,
  output logic                      halted,
  output logic [ADDR_W-1:0]         pc,
  output logic [COUNT_W-1:0]        instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t                    r_state;
  state_t                    w_nextState;
  logic                      w_retire;
  logic                      w_halt;
  logic                      w_restart;

  logic [ADDR_W-1:0]         r_pc;
  logic                      r_pmRd;
  logic [OPC_W-1:0]          r_opCode;
  logic [DATA_W-OPC_W-1:0]   r_operand;
  logic                      r_instrValid;
  logic                      r_halted;
  logic [COUNT_W-1:0]        r_instrCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_retire    = 1'b0;
    w_halt      = 1'b0;
    w_restart   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_nextState = S_FETCH;
      end
      S_FETCH: w_nextState = S_WAIT;
      S_WAIT:  w_nextState = S_EXEC;
      S_EXEC: begin
        if (WrPC) begin
          w_nextState = S_FETCH;
          w_retire    = 1'b1;
        end else if (r_opCode == '0) begin
          w_nextState = S_HALTED;
          w_halt      = 1'b1;
        end
      end
      S_HALTED: begin
        if (start) begin
          w_nextState = S_FETCH;
          w_restart   = 1'b1;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // pm_rd is registered off the next state so the strobe lines up with FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc         <= '0;
      r_pmRd       <= 1'b0;
      r_opCode     <= '0;
      r_operand    <= '0;
      r_instrValid <= 1'b0;
      r_halted     <= 1'b0;
      r_instrCount <= '0;
    end else begin
      r_pmRd <= (w_nextState == S_FETCH);

      if (r_state == S_WAIT) begin
        r_opCode     <= instr_data[DATA_W-1 -: OPC_W];
        r_operand    <= instr_data[DATA_W-OPC_W-1:0];
        r_instrValid <= 1'b1;
      end

      if (w_retire) begin
        r_pc         <= r_pc + ADDR_W'(1);
        r_instrValid <= 1'b0;
        if (!(&r_instrCount)) begin
          r_instrCount <= r_instrCount + COUNT_W'(1);
        end
      end

      if (w_halt) begin
        r_halted <= 1'b1;
      end

      if (w_restart) begin
        r_halted     <= 1'b0;
        r_pc         <= '0;
        r_instrValid <= 1'b0;
        r_instrCount <= '0;
      end
    end
  end

  assign pm_addr     = r_pc;
  assign pc          = r_pc;
  assign pm_rd       = r_pmRd;
  assign OpCode      = r_opCode;
  assign Operand     = r_operand;
  assign instr_valid = r_instrValid;
  assign halted      = r_halted;
  assign instr_count = r_instrCount;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: cycle tables, hand-written corner
// sequences, a fetch scoreboard and a small-width wrap/saturation instance.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, default widths
  logic        reset;
  logic        start;
  logic        stallForce;
  logic        WrPC;
  logic [15:0] instr_data;
  logic [10:0] pm_addr;
  logic        pm_rd;
  logic [4:0]  OpCode;
  logic [10:0] Operand;
  logic        instr_valid;
  logic        halted;
  logic [10:0] pc;
  logic [15:0] instr_count;

  // Narrow instance for wrap and saturation
  logic        start2;
  logic        WrPC2;
  logic [15:0] instr_data2;
  logic [2:0]  pm_addr2;
  logic        pm_rd2;
  logic [4:0]  OpCode2;
  logic [10:0] Operand2;
  logic        instr_valid2;
  logic        halted2;
  logic [2:0]  pc2;
  logic [1:0]  instr_count2;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:7];
  logic [15:0] expQ [$];
  logic        prevValid = 1'b0;

  // Decoder stand-in: every non-HLT opcode retires unless the bench forces a stall
  assign WrPC  = !stallForce && (OpCode != 5'd0);
  assign WrPC2 = (OpCode2 != 5'd0);

  instruction_fetch dut (
    .clk(clk), .reset(reset), .start(start), .WrPC(WrPC), .instr_data(instr_data),
    .pm_addr(pm_addr), .pm_rd(pm_rd), .OpCode(OpCode), .Operand(Operand),
    .instr_valid(instr_valid), .halted(halted), .pc(pc), .instr_count(instr_count)
  );

  instruction_fetch #(.ADDR_W(3), .OPC_W(5), .DATA_W(16), .COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .WrPC(WrPC2), .instr_data(instr_data2),
    .pm_addr(pm_addr2), .pm_rd(pm_rd2), .OpCode(OpCode2), .Operand(Operand2),
    .instr_valid(instr_valid2), .halted(halted2), .pc(pc2), .instr_count(instr_count2)
  );

  // Synchronous program memories with one cycle of read latency
  always @(posedge clk) begin
    if (pm_rd) instr_data <= mem[pm_addr[2:0]];
    if (pm_rd2) instr_data2 <= {5'd1, 8'd0, pm_addr2};
  end

  task automatic checkField(input string name, input string field,
                            input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%0h required=%0h", name, field, act, expv);
    end
  endtask

  // Scoreboard: each observed read pushes the word the bench stored there;
  // each new instruction under execution pops and compares it.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
    end else begin
      if (pm_rd) expQ.push_back(mem[pm_addr[2:0]]);
      if (instr_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkField("scoreboard", "empty", 32'd1, 32'd0);
        end else begin
          checkField("scoreboard", "instr", {OpCode, Operand}, expQ.pop_front());
        end
      end
    end
    prevValid = instr_valid;
  end

  typedef struct {
    logic        startV;
    logic        stallV;
    logic        expRd;
    logic [10:0] expAddr;
    logic [4:0]  expOp;
    logic [10:0] expOper;
    logic        expValid;
    logic        expHalt;
    logic [15:0] expCnt;
  } vec_t;

  vec_t vecQ [$];

  task automatic addVec(input logic s, input logic st, input logic rd, input logic [10:0] a,
                        input logic [4:0] op, input logic [10:0] oper, input logic v,
                        input logic h, input logic [15:0] c);
    vec_t t;
    t.startV = s; t.stallV = st; t.expRd = rd; t.expAddr = a; t.expOp = op;
    t.expOper = oper; t.expValid = v; t.expHalt = h; t.expCnt = c;
    vecQ.push_back(t);
  endtask

  // Drive inputs for the current cycle, then move to just after the next edge
  task automatic applyStimulus(input logic s, input logic st, input logic r);
    start      = s;
    stallForce = st;
    reset      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic expRd, input logic [10:0] expAddr,
                             input logic [4:0] expOp, input logic [10:0] expOper,
                             input logic expValid, input logic expHalt, input logic [15:0] expCnt);
    checkField(name, "pm_rd", pm_rd, expRd);
    checkField(name, "pm_addr", pm_addr, expAddr);
    checkField(name, "pc", pc, expAddr);
    checkField(name, "OpCode", OpCode, expOp);
    checkField(name, "Operand", Operand, expOper);
    checkField(name, "instr_valid", instr_valid, expValid);
    checkField(name, "halted", halted, expHalt);
    checkField(name, "instr_count", instr_count, expCnt);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fetches;
    reset = 1'b1; start = 1'b0; stallForce = 1'b0; start2 = 1'b0;
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0000; mem[3] = 16'h0000;
    mem[4] = 16'h0000; mem[5] = 16'h0000; mem[6] = 16'h0000; mem[7] = 16'h0000;

    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 1);
    checkOutput("reset", 0, 0, 0, 0, 0, 0, 0);

    // Straight program LDI 5, ADDI 3, HLT; start also pulsed in FETCH and WAIT
    addVec(1, 0, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 3, 5, 1, 0, 0);
    addVec(0, 0, 1, 1, 3, 5, 0, 0, 1);
    addVec(0, 0, 0, 1, 3, 5, 0, 0, 1);
    addVec(0, 0, 0, 1, 5, 3, 1, 0, 1);
    addVec(0, 0, 1, 2, 5, 3, 0, 0, 2);
    addVec(0, 0, 0, 2, 5, 3, 0, 0, 2);
    addVec(0, 0, 0, 2, 0, 0, 1, 0, 2);
    addVec(0, 0, 0, 2, 0, 0, 1, 1, 2);
    addVec(0, 0, 0, 2, 0, 0, 1, 1, 2);
    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i].startV, vecQ[i].stallV, 0);
      checkOutput($sformatf("prog%0d", i + 1), vecQ[i].expRd, vecQ[i].expAddr, vecQ[i].expOp,
                  vecQ[i].expOper, vecQ[i].expValid, vecQ[i].expHalt, vecQ[i].expCnt);
    end

    // Restart from HALTED into an opcode-4 instruction, then stall it
    mem[0] = 16'h2007;
    applyStimulus(1, 0, 0);
    checkOutput("restart", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("restartWait", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("stallExec", 0, 0, 4, 7, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus((k == 1), 1, 0);
      checkOutput($sformatf("stall%0d", k), 0, 0, 4, 7, 1, 0, 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("release", 1, 1, 4, 7, 0, 0, 1);
    applyStimulus(0, 0, 0);
    checkOutput("releaseWait", 0, 1, 4, 7, 0, 0, 1);
    applyStimulus(0, 1, 0);
    checkOutput("secondExec", 0, 1, 5, 3, 1, 0, 1);

    // Reset while stalled in EXEC, then confirm IDLE holds without start
    applyStimulus(0, 1, 1);
    checkOutput("rstExec", 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("idle%0d", k), 0, 0, 0, 0, 0, 0, 0);
    end

    // Reset during WAIT must not latch the word being returned
    applyStimulus(1, 0, 0);
    checkOutput("fetchPreRst", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("waitPreRst", 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1);
    checkOutput("rstWait", 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("idleAfterWait%0d", k), 0, 0, 0, 0, 0, 0, 0);
    end
    applyStimulus(1, 0, 0);
    checkOutput("startAfterRst", 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("execAfterRst", 0, 0, 4, 7, 1, 0, 0);
    applyStimulus(0, 0, 0);
    checkOutput("retireAfterRst", 1, 1, 4, 7, 0, 0, 1);
    applyStimulus(0, 0, 1);
    checkField("scoreboard", "drained", expQ.size(), 0);

    // Narrow instance: PC wraps after 7, count saturates at 3
    applyStimulus(0, 0, 0);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    fetches = 0;
    for (int cyc = 0; cyc < 60 && fetches < 10; cyc++) begin
      if (pm_rd2) begin
        checkField($sformatf("wrap%0d", fetches), "pm_addr", pm_addr2, fetches % 8);
        checkField($sformatf("wrap%0d", fetches), "instr_count", instr_count2,
                   (fetches < 3) ? fetches : 3);
        fetches++;
      end
      @(posedge clk);
      #1;
    end
    checkField("wrap", "fetches", fetches, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
